latch_write_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares one level-sensitive D-latch storage word between several requesters. It grants one write at a time and drives the latch data and enable with guaranteed setup and hold margins: data is stable before, during and after the enable window. It sits between the requesting logic and the latch bank, so no requester ever drives the latch enable directly.

---
 rtl/latch_write_arbiter_if.sv | 36 +++
 rtl/latch_write_arbiter.sv | 96 +++++++++
 tb/tb_latch_write_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/latch_write_arbiter_if.sv
// Requester-side and latch-side signals of the shared latch write arbiter.
// The slave modport is the arbiter; the master modport is the requester/latch environment.
interface latch_write_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned IdW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       lat_d;
  logic                    lat_en;
  logic [IdW-1:0]          grant_id;
  logic                    busy;

  modport slave (
    input  req,
    input  wdata,
    output ack,
    output lat_d,
    output lat_en,
    output grant_id,
    output busy
  );

  modport master (
    output req,
    output wdata,
    input  ack,
    input  lat_d,
    input  lat_en,
    input  grant_id,
    input  busy
  );
endinterface

// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter sequencing writes into a shared D-latch word so lat_d is stable
// for a full cycle before, during and after the lat_en window.
module latch_write_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned EN_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  latch_write_arbiter_if.slave bus
);
  localparam int unsigned IdW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StEnable, StHold} state_e;

  state_e            state_q;
  logic [IdW-1:0]    ptr_q;
  logic [IdW-1:0]    grant_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] lat_d_q;
  logic              lat_en_q;
  logic [N_REQ-1:0]  ack_q;
  logic              busy_q;

  logic              win_valid;
  logic [IdW-1:0]    win_idx;
  logic [IdW-1:0]    ptr_d;
  int unsigned       j;

  // First requesting index at or after ptr_q, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = (32'(ptr_q) + k) % N_REQ;
      if (!win_valid && bus.req[j]) begin
        win_valid = 1'b1;
        win_idx   = IdW'(j);
      end
    end
    ptr_d = (win_idx == IdW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      lat_d_q  <= '0;
      lat_en_q <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            state_q <= StSetup;
            grant_q <= win_idx;
            lat_d_q <= bus.wdata[int'(win_idx) * int'(DATA_W) +: DATA_W];
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
          end
        end
        StSetup: begin
          state_q  <= StEnable;
          lat_en_q <= 1'b1;
          cnt_q    <= CntW'(EN_CYCLES - 1);
        end
        StEnable: begin
          if (cnt_q == '0) begin
            state_q  <= StHold;
            lat_en_q <= 1'b0;
            ack_q    <= {{(N_REQ - 1){1'b0}}, 1'b1} << grant_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          state_q <= StIdle;
          ack_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.lat_d    = lat_d_q;
  assign bus.lat_en   = lat_en_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: a transaction-phase model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_latch_write_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned EN = 2;

  logic clk;
  logic rst;
  int   checks;
  int   passes;
  bit   auto_drop;

  latch_write_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  latch_write_arbiter #(.N_REQ(N), .DATA_W(DW), .EN_CYCLES(EN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // Model: phase 0 = idle, 1 = setup, 2..EN+1 = enable, EN+2 = hold.
  int          m_phase;
  int          m_ptr;
  int          m_grant;
  logic [7:0]  m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_ptr   = 0;
      m_grant = 0;
      m_data  = 8'h00;
    end else if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (m_phase == 0 && bus.req[i]) begin
          m_phase = 1;
          m_grant = i;
          m_data  = bus.wdata[i*DW +: DW];
          m_ptr   = (i + 1) % N;
        end
      end
    end else begin
      m_phase = (m_phase == EN + 2) ? 0 : m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [3:0] e_ack;
      e_ack = (m_phase == EN + 2) ? (4'b0001 << m_grant) : 4'b0000;
      chk("m_lat_en", 32'(bus.lat_en), 32'(m_phase >= 2 && m_phase <= EN + 1));
      chk("m_ack", 32'(bus.ack), 32'(e_ack));
      chk("m_busy", 32'(bus.busy), 32'(m_phase != 0));
      chk("m_lat_d", 32'(bus.lat_d), 32'(m_data));
      chk("m_grant_id", 32'(bus.grant_id), 32'(m_grant));
    end
  end

  // Requesters drop their bit at the edge where they see ack.
  task automatic tick();
    @(negedge clk);
    if (auto_drop) bus.req = bus.req & ~bus.ack;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    auto_drop = 1'b1;
    rst       = 1'b1;
    bus.req   = '0;
    bus.wdata = '0;
    #2;
    chk("rst_lat_en", 32'(bus.lat_en), 32'h0);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_lat_d", 32'(bus.lat_d), 32'h0);
    chk("rst_grant", 32'(bus.grant_id), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Single request
    bus.wdata[7:0] = 8'hA5;
    bus.req        = 4'b0001;
    tick();
    chk("single_c1_lat_d", 32'(bus.lat_d), 32'hA5);
    chk("single_c1_lat_en", 32'(bus.lat_en), 32'h0);
    tick();
    chk("single_c2_lat_en", 32'(bus.lat_en), 32'h1);
    tick();
    chk("single_c3_lat_en", 32'(bus.lat_en), 32'h1);
    tick();
    chk("single_c4_ack", 32'(bus.ack), 32'h1);
    chk("single_c4_lat_en", 32'(bus.lat_en), 32'h0);
    tick();
    chk("single_c5_busy", 32'(bus.busy), 32'h0);

    // Full contention from a fresh pointer
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    bus.wdata = 32'h44332211;
    bus.req   = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      logic [31:0] dv;
      dv = 32'h44332211;
      tick();
      chk("cont_grant", 32'(bus.grant_id), 32'(g));
      chk("cont_lat_d", 32'(bus.lat_d), 32'(dv[g*8 +: 8]));
      repeat (4) tick();
    end
    chk("cont_req_drained", 32'(bus.req), 32'h0);

    // Rotation: granting 2 leaves ptr=3, so 0 wins over 2
    bus.req = 4'b0100;
    tick();
    chk("rot_first", 32'(bus.grant_id), 32'h2);
    repeat (4) tick();
    bus.req = 4'b0101;
    tick();
    chk("rot_wrap_grant", 32'(bus.grant_id), 32'h0);
    chk("rot_wrap_lat_d", 32'(bus.lat_d), 32'h11);
    repeat (4) tick();
    tick();
    chk("rot_then_2", 32'(bus.grant_id), 32'h2);
    repeat (4) tick();

    // Data freeze and request drop
    bus.wdata[15:8] = 8'h3C;
    bus.req         = 4'b0010;
    tick();
    chk("frz_c1_lat_d", 32'(bus.lat_d), 32'h3C);
    tick();
    bus.wdata[15:8] = 8'hFF;
    bus.req[1]      = 1'b0;
    tick();
    chk("frz_c3_lat_d", 32'(bus.lat_d), 32'h3C);
    tick();
    chk("frz_c4_ack", 32'(bus.ack), 32'h2);
    chk("frz_c4_lat_d", 32'(bus.lat_d), 32'h3C);
    tick();
    chk("frz_c5_lat_d", 32'(bus.lat_d), 32'h3C);

    // Reset mid-ENABLE: grant 2 moves ptr to 3, reset must restore 0
    bus.wdata[23:16] = 8'h77;
    bus.req          = 4'b0100;
    tick();
    tick();
    chk("rmid_lat_en", 32'(bus.lat_en), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rmid_async_lat_en", 32'(bus.lat_en), 32'h0);
    chk("rmid_async_ack", 32'(bus.ack), 32'h0);
    chk("rmid_async_busy", 32'(bus.busy), 32'h0);
    tick();
    bus.req = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    chk("rmid_lat_d", 32'(bus.lat_d), 32'h0);
    chk("rmid_grant", 32'(bus.grant_id), 32'h0);
    chk("rmid_ack", 32'(bus.ack), 32'h0);
    bus.wdata[15:8]  = 8'h5A;
    bus.wdata[31:24] = 8'hC3;
    bus.req          = 4'b1010;
    tick();
    chk("rmid_ptr0_grant", 32'(bus.grant_id), 32'h1);
    chk("rmid_ptr0_lat_d", 32'(bus.lat_d), 32'h5A);
    repeat (4) tick();
    tick();
    chk("rmid_next_grant", 32'(bus.grant_id), 32'h3);
    chk("rmid_next_lat_d", 32'(bus.lat_d), 32'hC3);
    repeat (4) tick();

    // Idle stability
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_lat_en", 32'(bus.lat_en), 32'h0);
      chk("idle_ack", 32'(bus.ack), 32'h0);
      chk("idle_busy", 32'(bus.busy), 32'h0);
      chk("idle_lat_d", 32'(bus.lat_d), 32'hC3);
      chk("idle_grant", 32'(bus.grant_id), 32'h3);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
